// File: rtl/grid_life_engine_axil_if.sv
// rtl/grid_life_engine_axil_if.sv - AXI4-Lite slave bus bundle for the life engine
interface grid_life_engine_axil_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 9
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/grid_life_engine_axil.sv
// rtl/grid_life_engine_axil.sv - AXI4-Lite Conway Life (B3/S23) grid with double-buffered step engine
module grid_life_engine_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 9,
    parameter int GRID_W             = 32,
    parameter int GRID_H             = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    grid_life_engine_axil_if.slave s_axi,
    output logic                   busy,
    output logic                   irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;
    localparam int WW = AW - 2;
    localparam int RW = $clog2(GRID_H);

    localparam logic [WW-1:0] ROW_BASE    = WW'(64);
    localparam logic [WW:0]   ROW_END     = (WW+1)'(64 + GRID_H);
    localparam logic [RW-1:0] LAST_ROW    = RW'(GRID_H - 1);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {K_CTRL, K_STATUS, K_GEN, K_STEPS, K_ROW, K_BAD} kind_t;
    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SWAP} state_t;

    logic [GRID_W-1:0] grid [2][GRID_H];
    logic              cur_sel;

    logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;

    logic          ctrl_wrap, ctrl_irq_en, done, busy_q, wrap_run;
    logic [31:0]   gen_count;
    logic [DW-1:0] steps, remaining;
    state_t        state;
    logic [RW-1:0] row_cnt;

    function automatic kind_t decode(input logic [AW-1:0] a);
        logic [WW-1:0] wi;
        wi = a[AW-1:2];
        if (a[1:0] != 2'b00)                           return K_BAD;
        if (wi == WW'(0))                              return K_CTRL;
        if (wi == WW'(1))                              return K_STATUS;
        if (wi == WW'(2))                              return K_GEN;
        if (wi == WW'(3))                              return K_STEPS;
        if (wi >= ROW_BASE && {1'b0, wi} < ROW_END)    return K_ROW;
        return K_BAD;
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
        return RW'(a[AW-1:2] - ROW_BASE);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < SW; b++)
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    kind_t         wr_kind, rd_kind;
    logic [RW-1:0] wr_row, rd_row;
    logic          wr_hs, rd_hs, start_go;
    logic [1:0]    wr_resp, rd_resp;
    logic [DW-1:0] rd_data;

    always_comb begin
        wr_kind  = decode(s_axi.S_AXI_AWADDR);
        rd_kind  = decode(s_axi.S_AXI_ARADDR);
        wr_row   = row_of(s_axi.S_AXI_AWADDR);
        rd_row   = row_of(s_axi.S_AXI_ARADDR);
        wr_hs    = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
        rd_hs    = arready_q & s_axi.S_AXI_ARVALID;
        start_go = wr_hs && (wr_kind == K_CTRL) && s_axi.S_AXI_WSTRB[0]
                   && s_axi.S_AXI_WDATA[0] && !busy_q;
        wr_resp  = ((wr_kind == K_BAD) || (wr_kind == K_ROW && busy_q)) ? RESP_SLVERR : RESP_OKAY;
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_kind)
            K_CTRL:   rd_data = DW'({ctrl_irq_en, ctrl_wrap, 1'b0});
            K_STATUS: rd_data = DW'({done, busy_q});
            K_GEN:    rd_data = DW'(gen_count);
            K_STEPS:  rd_data = steps;
            K_ROW: begin
                if (busy_q) rd_resp = RESP_SLVERR;
                else        rd_data = DW'(grid[cur_sel][rd_row]);
            end
            default:  rd_resp = RESP_SLVERR;
        endcase
    end

    // Neighbour rows of the row being computed; missing rows read as dead when not wrapping.
    logic [RW-1:0]     up_idx, dn_idx;
    logic              up_ok, dn_ok;
    logic [GRID_W-1:0] row_up, row_mid, row_dn, next_row;

    always_comb begin
        up_idx  = (row_cnt == '0) ? LAST_ROW : row_cnt - RW'(1);
        dn_idx  = (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
        up_ok   = wrap_run || (row_cnt != '0);
        dn_ok   = wrap_run || (row_cnt != LAST_ROW);
        row_up  = up_ok ? grid[cur_sel][up_idx] : '0;
        row_mid = grid[cur_sel][row_cnt];
        row_dn  = dn_ok ? grid[cur_sel][dn_idx] : '0;
    end

    for (genvar c = 0; c < GRID_W; c++) begin : g_col
        localparam int CL = (c == 0) ? GRID_W - 1 : c - 1;
        localparam int CR = (c == GRID_W - 1) ? 0 : c + 1;
        logic       l_ok, r_ok;
        logic [3:0] n;
        assign l_ok = wrap_run || (c != 0);
        assign r_ok = wrap_run || (c != GRID_W - 1);
        assign n = 4'(row_up[c]) + 4'(row_dn[c])
                 + 4'(l_ok & row_up[CL]) + 4'(l_ok & row_mid[CL]) + 4'(l_ok & row_dn[CL])
                 + 4'(r_ok & row_up[CR]) + 4'(r_ok & row_mid[CR]) + 4'(r_ok & row_dn[CR]);
        assign next_row[c] = (n == 4'd3) || (row_mid[c] && (n == 4'd2));
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
            ctrl_wrap   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            done        <= 1'b0;
            busy_q      <= 1'b0;
            wrap_run    <= 1'b0;
            gen_count   <= '0;
            steps       <= '0;
            remaining   <= '0;
            state       <= S_IDLE;
            row_cnt     <= '0;
            cur_sel     <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < GRID_H; r++)
                    grid[b][r] <= '0;
        end else begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
                case (wr_kind)
                    K_CTRL: if (s_axi.S_AXI_WSTRB[0]) begin
                        ctrl_wrap   <= s_axi.S_AXI_WDATA[1];
                        ctrl_irq_en <= s_axi.S_AXI_WDATA[2];
                    end
                    K_STATUS: if (s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[1]) done <= 1'b0;
                    K_STEPS:  steps <= merge(steps, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                    K_ROW: if (!busy_q)
                        grid[cur_sel][wr_row] <= GRID_W'(merge(DW'(grid[cur_sel][wr_row]),
                                                               s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB));
                    default: ;
                endcase
            end else if (!bvalid_q && !awready_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                awready_q <= 1'b1;
                wready_q  <= 1'b1;
            end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= 1'b0;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (!rvalid_q && !arready_q && s_axi.S_AXI_ARVALID) begin
                arready_q <= 1'b1;
            end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end

            // Engine updates come last so a completion beats a same-cycle DONE clear.
            case (state)
                S_IDLE: if (start_go) begin
                    state     <= S_COMPUTE;
                    row_cnt   <= '0;
                    wrap_run  <= s_axi.S_AXI_WDATA[1];
                    remaining <= (steps == '0) ? DW'(1) : steps;
                    done      <= 1'b0;
                    busy_q    <= 1'b1;
                end
                S_COMPUTE: begin
                    grid[~cur_sel][row_cnt] <= next_row;
                    if (row_cnt == LAST_ROW) state <= S_SWAP;
                    else                     row_cnt <= row_cnt + RW'(1);
                end
                S_SWAP: begin
                    cur_sel   <= ~cur_sel;
                    gen_count <= gen_count + 32'd1;
                    remaining <= remaining - DW'(1);
                    row_cnt   <= '0;
                    if (remaining == DW'(1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        state <= S_COMPUTE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign busy                = busy_q;
    assign irq                 = done & ctrl_irq_en;
endmodule

// File: doc/grid_life_engine_axil.md
Name: grid_life_engine_axil

Overview:
Parametrised AXI4-Lite slave that holds a GRID_W x GRID_H single-bit cell grid, stored one row per data word.
A hardware step engine advances the grid by N generations of Conway's Life (B3/S23) on command.
It is the successor to the fixed 4-register 32-bit grid controller and sits behind the PS master on the same AXI-Lite interconnect.
Status and interrupt outputs report completion.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; must be at least GRID_W.
C_S_AXI_ADDR_WIDTH, 9, byte-address width; must cover 0x100 + 4*GRID_H.
GRID_W, 32, cells per row (1..C_S_AXI_DATA_WIDTH).
GRID_H, 32, number of rows (3..64).

Ports:
ACLK  in  1  clock.
ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
busy  out  1  engine running.
irq  out  1  level interrupt, equal to DONE & IRQ_EN.

Behaviour:
- Reset (asynchronous):
  - All AXI ready/valid outputs, RDATA, BRESP, RRESP, busy and irq are 0.
  - Both grid buffers are cleared to 0; all registers are cleared to 0; engine state is IDLE.
  - Asserting reset mid-generation aborts the run with no partial-state retention.
- Register map (byte offsets):
  - 0x00 CTRL (RW): bit0 START, write-1 self-clearing, reads 0; bit1 WRAP; bit2 IRQ_EN.
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C).
  - 0x08 GEN_COUNT (RO): 32-bit total generations completed; wraps modulo 2^32.
  - 0x0C STEPS (RW): generations per START; a value of 0 is treated as 1.
  - 0x100 + 4*r: grid row r, bit c = cell (r,c). Bits at or above GRID_W are ignored on write and read as 0.
- Decode and responses:
  - Any other address returns SLVERR; reads of it return 0.
  - WSTRB is honoured per byte on RW registers.
- Write channel:
  - AWREADY and WREADY pulse together for 1 cycle when AWVALID & WVALID & !BVALID.
  - BVALID asserts the next cycle and holds until BREADY.
  - No write is accepted while BVALID is high.
- Read channel:
  - ARREADY pulses for 1 cycle when ARVALID & !RVALID.
  - RVALID and RDATA are valid the next cycle and hold until RREADY.
- Access while BUSY:
  - Grid-row writes are dropped with SLVERR. Grid-row reads return 0 with SLVERR.
  - Register accesses proceed normally.
  - START written while BUSY is ignored (response OKAY).
- Engine FSM (IDLE, COMPUTE, SWAP):
  - IDLE -> COMPUTE on the cycle after an accepted START write. This latches WRAP and loads remaining = max(STEPS,1), clears DONE, and raises BUSY.
  - COMPUTE: one row per cycle, r = 0..GRID_H-1. Reads rows r-1, r, r+1 from the current buffer and writes next(r) into the other buffer.
  - COMPUTE -> SWAP after row GRID_H-1.
  - SWAP (1 cycle): flip the buffer select, GEN_COUNT += 1, remaining -= 1. Go to COMPUTE if remaining != 0. Otherwise go to IDLE with BUSY=0 and DONE=1.
  - Latency: GRID_H+1 cycles per generation; BUSY is high for STEPS*(GRID_H+1) cycles.
- Cell rule:
  - n = number of live cells among the 8 neighbours.
  - Live next = (n==3) | (alive & n==2).
  - WRAP=1: toroidal indexing, row r-1 mod GRID_H and column c±1 mod GRID_W.
  - WRAP=0: neighbours outside the grid count as dead.
- AXI grid accesses always address the current (visible) buffer.
- Simultaneous W1C of DONE and engine completion in the same cycle: the engine set wins, so DONE=1.

Test Plan:
1. Register access (GRID 32x32): write STEPS=5 and read it back -> 5, OKAY. Read 0x040 -> 0, SLVERR. Write row 3 = 0xFFFF_FFFF with WSTRB=0x1 -> reads 0x0000_00FF.
2. Blinker: row10 = 0x0000_1C00, START with WRAP=0.
   - busy is high for exactly 33 cycles.
   - Then rows 9, 10, 11 each read 0x0000_0800 and all other rows read 0.
   - GEN_COUNT=1, STATUS=0x2.
3. Edge wrap: row0 = 0x8000_0003.
   - WRAP=1 -> rows 31, 0, 1 each read 0x0000_0001.
   - Same start pattern with WRAP=0 -> all rows read 0.
4. Multi-step and irq: CTRL=0x5 (IRQ_EN plus START) with STEPS=2 on the blinker.
   - busy is high for 66 cycles and the grid returns to the original pattern.
   - GEN_COUNT increments by 2 and irq goes to 1.
   - Writing STATUS=0x2 drops irq to 0.
5. Busy protection:
   - A write to row 5 during busy -> SLVERR, row unchanged afterwards.
   - A second START during busy -> no extra generation (GEN_COUNT unchanged by it).
6. Mid-run reset: deassert ARESETN at cycle 10 of COMPUTE.
   - busy, irq, BVALID and RVALID go to 0 immediately.
   - After release, all rows and GEN_COUNT read 0.
